// File: rtl/cache_write_buffer_fifo.sv
// Multi-entry victim write buffer: queues dirty evicted lines and drains them
// to memory in push order, one beat at a time, with a line-address lookup port.
// Optional macro WB_COALESCE_EN: a push that matches a queued non-head line
// overwrites that line's data in place instead of allocating a new entry.
module cache_write_buffer_fifo #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BANK_NUM   = 4,
    parameter int unsigned BEAT_BANKS = 2,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               push_valid,
    output logic                               push_ready,
    input  logic [ADDR_WIDTH-1:0]              push_addr,
    input  logic [BANK_NUM*DATA_WIDTH-1:0]     push_data,
    output logic                               mem_valid,
    input  logic                               mem_ready,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    output logic [BEAT_BANKS*DATA_WIDTH-1:0]   mem_data,
    output logic                               mem_last,
    input  logic [ADDR_WIDTH-1:0]              lookup_addr,
    output logic                               lookup_hit,
    output logic [BANK_NUM*DATA_WIDTH-1:0]     lookup_data,
    output logic [$clog2(DEPTH):0]             count,
    output logic                               empty
);

    localparam int unsigned LINE_W   = BANK_NUM * DATA_WIDTH;
    localparam int unsigned BEAT_W   = BEAT_BANKS * DATA_WIDTH;
    localparam int unsigned BEATS    = BANK_NUM / BEAT_BANKS;
    localparam int unsigned BCNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned LINE_OFF = $clog2(LINE_W / 8);
    localparam int unsigned BEAT_OFF = $clog2(BEAT_W / 8);
    localparam logic [BCNT_W-1:0]     BEAT_MAX  = BCNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << LINE_OFF) - ADDR_WIDTH'(1));

    typedef enum logic {IDLE, SEND} state_t;

    state_t                   state_q, state_d;
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [BCNT_W-1:0]        beat_q;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DEPTH-1:0]         entry_valid;
    logic [ADDR_WIDTH-1:0]    entry_addr [DEPTH];
    logic [LINE_W-1:0]        entry_data [DEPTH];

    logic [ADDR_WIDTH-1:0]    push_line, lookup_line;
    logic                     push_fire, push_alloc, coal_hit, pop;
    logic [PTR_W-1:0]         lk_idx;

    assign push_line   = push_addr & LINE_MASK;
    assign lookup_line = lookup_addr & LINE_MASK;
    assign push_ready  = (cnt_q != CNT_W'(DEPTH));
    assign push_fire   = push_valid & push_ready;
    assign push_alloc  = push_fire & ~coal_hit;
    assign pop         = mem_valid & mem_ready & mem_last;
    assign count       = cnt_q;
    assign empty       = (cnt_q == '0);

`ifdef WB_COALESCE_EN
    logic [PTR_W-1:0] coal_idx;

    // Find a queued non-head entry holding the pushed line.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i] == push_line) &&
                (PTR_W'(i) != rd_ptr)) begin
                coal_hit = 1'b1;
                coal_idx = PTR_W'(i);
            end
        end
    end
`else
    assign coal_hit = 1'b0;
`endif

    // Drain FSM next-state and beat-level handshake outputs.
    always_comb begin
        state_d   = state_q;
        mem_valid = (state_q == SEND);
        mem_last  = (state_q == SEND) && (beat_q == BEAT_MAX);
        cnt_d     = cnt_q + CNT_W'(push_alloc) - CNT_W'(pop);
        case (state_q)
            IDLE:    if (push_alloc) state_d = SEND;
            SEND:    if (pop && (cnt_d == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, pointers, beat counter, occupancy and entry valid bits.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            beat_q      <= '0;
            cnt_q       <= '0;
            entry_valid <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (mem_valid && mem_ready) begin
                beat_q <= mem_last ? '0 : beat_q + BCNT_W'(1);
            end
            if (pop) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr              <= rd_ptr + PTR_W'(1);
            end
            if (push_alloc) begin
                entry_valid[wr_ptr] <= 1'b1;
                wr_ptr              <= wr_ptr + PTR_W'(1);
            end
        end
    end

    // Line address/data storage; validity is tracked separately so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_alloc) begin
            entry_addr[wr_ptr] <= push_line;
            entry_data[wr_ptr] <= push_data;
        end
`ifdef WB_COALESCE_EN
        if (push_fire && coal_hit) begin
            entry_data[coal_idx] <= push_data;
        end
`endif
    end

    // Head beat presentation: beat-adjusted address and selected banks.
    always_comb begin
        mem_addr = entry_addr[rd_ptr] + (ADDR_WIDTH'(beat_q) << BEAT_OFF);
        mem_data = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BCNT_W'(b)) begin
                mem_data = entry_data[rd_ptr][b*BEAT_W +: BEAT_W];
            end
        end
    end

    // Lookup scans oldest to youngest so the youngest match wins.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        lk_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = rd_ptr + PTR_W'(i);
            if (entry_valid[lk_idx] && (entry_addr[lk_idx] == lookup_line)) begin
                lookup_hit  = 1'b1;
                lookup_data = entry_data[lk_idx];
            end
        end
    end

endmodule

// File: tb/tb_cache_write_buffer_fifo.sv
// Directed self-checking bench for cache_write_buffer_fifo with a line-level
// scoreboard checked on every memory beat handshake.
module tb_cache_write_buffer_fifo;

    localparam int unsigned AW = 64;
    localparam int unsigned LW = 256;
    localparam int unsigned BW = 128;
    localparam int unsigned NBEATS = 2;

    logic          clk = 1'b0;
    logic          rstn, push_valid, push_ready, mem_valid, mem_ready, mem_last;
    logic          lookup_hit, empty;
    logic [AW-1:0] push_addr, mem_addr, lookup_addr;
    logic [LW-1:0] push_data, lookup_data;
    logic [BW-1:0] mem_data;
    logic [2:0]    count;

    cache_write_buffer_fifo dut (
        .clk(clk), .rstn(rstn),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_addr(push_addr), .push_data(push_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_last(mem_last),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [LW-1:0] d;
    } line_t;

    line_t         mq[$];
    int            beat_i = 0;
    int            total = 0;
    int            bad = 0;
    int            hs_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [BW-1:0] prev_data;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] mk_data();
        logic [LW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic void model_push(input logic [AW-1:0] a, input logic [LW-1:0] d);
        line_t t;
`ifdef WB_COALESCE_EN
        for (int i = 1; i < mq.size(); i++) begin
            if (mq[i].a == a) begin
                mq[i].d = d;
                return;
            end
        end
`endif
        t.a = a;
        t.d = d;
        mq.push_back(t);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_push(input logic [AW-1:0] a, input logic [LW-1:0] d, output bit acc);
        push_valid = 1'b1;
        push_addr  = a;
        push_data  = d;
        @(negedge clk);
        acc = push_ready;
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        if (acc) model_push(a & ~64'h1F, d);
    endtask

    task automatic drain(input int lim);
        int k = 0;
        mem_ready = 1'b1;
        while (!empty && k < lim) begin
            step(1);
            k++;
        end
        chk("drain_empty", empty, 1);
        chk("drain_model_empty", mq.size(), 0);
        mem_ready = 1'b0;
    endtask

    // Scoreboard: every handshake beat must match the oldest queued line; stalls must hold.
    always @(negedge clk) begin
        line_t l;
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", mem_valid, 1);
                chk("hold_addr", mem_addr, prev_addr);
                chk("hold_data", mem_data, prev_data);
            end
            prev_stall = mem_valid && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_data;
            if (mem_valid && mem_ready) begin
                hs_cnt++;
                if (mq.size() == 0) begin
                    chk("sb_unexpected_beat", 1, 0);
                end else begin
                    l = mq[0];
                    chk("sb_addr", mem_addr, l.a + 64'(beat_i * 16));
                    chk("sb_data", mem_data, l.d[beat_i*BW +: BW]);
                    chk("sb_last", mem_last, (beat_i == NBEATS - 1));
                    if (beat_i == NBEATS - 1) begin
                        beat_i = 0;
                        void'(mq.pop_front());
                    end else begin
                        beat_i++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] d0, dx, da, db, dc;
        logic [LW-1:0] dl[4];
        bit            acc;
        int            h0, acc_cyc;

        rstn = 1'b0; push_valid = 1'b0; mem_ready = 1'b0;
        push_addr = '0; push_data = '0; lookup_addr = '0;
        step(2);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_last", mem_last, 0);
        chk("rst_lookup_hit", lookup_hit, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_push_ready", push_ready, 1);
        rstn = 1'b1;
        step(1);

        // Single line, two beats, memory always ready.
        d0 = mk_data();
        mem_ready = 1'b1;
        do_push(64'h1000, d0, acc);
        chk("t1_accept", acc, 1);
        chk("t1_valid_latency", mem_valid, 1);
        chk("t1_beat0_addr", mem_addr, 64'h1000);
        chk("t1_beat0_data", mem_data, d0[127:0]);
        chk("t1_beat0_last", mem_last, 0);
        step(1);
        chk("t1_beat1_addr", mem_addr, 64'h1010);
        chk("t1_beat1_data", mem_data, d0[255:128]);
        chk("t1_beat1_last", mem_last, 1);
        step(1);
        chk("t1_empty", empty, 1);
        chk("t1_idle_valid", mem_valid, 0);

        // Fill while memory stalls; fifth push rejected; drain in order with pointer wrap.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dl[i] = mk_data();
            do_push(64'h5000 + 64'(i * 32'h1000), dl[i], acc);
            chk("t2_accept", acc, 1);
        end
        chk("t2_full_count", count, 4);
        chk("t2_full_ready", push_ready, 0);
        do_push(64'hA000, mk_data(), acc);
        chk("t2_fifth_rejected", acc, 0);
        chk("t2_count_after_fifth", count, 4);
        lookup_addr = 64'h7008;
        #1;
        chk("t2_lookup_hit", lookup_hit, 1);
        chk("t2_lookup_data", lookup_data, dl[2]);
        drain(40);
        chk("t2_count_zero", count, 0);

        // Stall pattern 1,0,0,1 during one line: exactly two handshakes.
        dx = mk_data();
        do_push(64'h7000, dx, acc);
        h0 = hs_cnt;
        mem_ready = 1'b1; step(1);
        mem_ready = 1'b0; step(2);
        chk("t3_stalled_last", mem_last, 1);
        mem_ready = 1'b1; step(1);
        mem_ready = 1'b0;
        chk("t3_handshakes", hs_cnt - h0, 2);
        chk("t3_empty", empty, 1);

        // Full buffer with push held across the last-beat pop: no bypass.
        for (int i = 0; i < 4; i++) do_push(64'hB000 + 64'(i * 32'h100), mk_data(), acc);
        chk("t4_full_count", count, 4);
        dx = mk_data();
        push_valid = 1'b1; push_addr = 64'hC000; push_data = dx;
        mem_ready = 1'b1;
        acc_cyc = -1;
        for (int c = 0; c < 8 && acc_cyc < 0; c++) begin
            @(negedge clk);
            acc = push_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                acc_cyc = c;
                model_push(64'hC000, dx);
            end
        end
        push_valid = 1'b0;
        mem_ready = 1'b0;
        chk("t4_accept_cycle", 32'(acc_cyc), 32'd2);
        chk("t4_count_kept", count, 4);
        drain(60);

        // Lookup on a queued line, miss on an absent line, miss after drain.
        da = mk_data();
        do_push(64'h2000, da, acc);
        lookup_addr = 64'h2008;
        #1;
        chk("t5_lookup_hit", lookup_hit, 1);
        chk("t5_lookup_data", lookup_data, da);
        lookup_addr = 64'h9000;
        #1;
        chk("t5_lookup_miss", lookup_hit, 0);
        lookup_addr = 64'h2008;
        drain(20);
        chk("t5_lookup_after_pop", lookup_hit, 0);

        // Reset in the middle of a line discards everything.
        do_push(64'hD000, mk_data(), acc);
        do_push(64'hE000, mk_data(), acc);
        mem_ready = 1'b1;
        step(1);
        rstn = 1'b0;
        step(1);
        mq.delete();
        beat_i = 0;
        chk("t6_rst_valid", mem_valid, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_empty", empty, 1);
        chk("t6_rst_last", mem_last, 0);
        rstn = 1'b1;
        step(1);
        chk("t6_no_valid_after_rst", mem_valid, 0);
        mem_ready = 1'b0;

        // Duplicate line pushes: coalesced or allocated depending on build.
        da = mk_data(); db = mk_data(); dc = mk_data();
        do_push(64'h3000, da, acc);
        do_push(64'h4000, db, acc);
        do_push(64'h4010, dc, acc);
`ifdef WB_COALESCE_EN
        chk("t7_count", count, 2);
`else
        chk("t7_count", count, 3);
`endif
        lookup_addr = 64'h4000;
        #1;
        chk("t7_lookup_hit", lookup_hit, 1);
        chk("t7_lookup_youngest", lookup_data, dc);
        drain(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
